// File: rtl/freq_lock_det.sv
// Frequency lock detector: measures the period of a divided feedback
// clock in sampling-clock cycles and reports fast/slow/lock/timeout.
//
// Ports:
//   clk            sampling clock (>= 4x fb_in)
//   rst_n          asynchronous active-low reset
//   en             synchronous enable, low forces IDLE
//   fb_in          feedback clock, asynchronous to clk
//   target_period  expected fb_in period in clk cycles
//   period         last measured fb_in period
//   period_vld     one-cycle pulse when period updates
//   fast / slow    last measurement below / above the lock window
//   locked         LOCK_N consecutive in-window measurements seen
//   timeout        no fb_in edge for 2^CNT_W-1 clk cycles
module freq_lock_det #(
    parameter int CNT_W  = 8,
    parameter int TOL    = 1,
    parameter int LOCK_N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fb_in,
    input  logic [CNT_W-1:0] target_period,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             fast,
    output logic             slow,
    output logic             locked,
    output logic             timeout
);

    localparam int WIN_W = $clog2(LOCK_N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_MEAS = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]   TOL_X    = (CNT_W + 1)'(TOL);
    localparam logic [WIN_W-1:0] WIN_FULL = WIN_W'(LOCK_N);

    // Synchronizer and edge history
    logic r_sync1;
    logic r_sync2;
    logic r_hist;

    // Control and measurement state
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt_run;
    logic [WIN_W-1:0] r_win;
    logic [CNT_W-1:0] r_period;
    logic             r_vld;
    logic             r_fast;
    logic             r_slow;
    logic             r_locked;
    logic             r_timeout;

    // Combinational helpers
    logic             w_edge;
    logic             w_active;
    logic             w_sat;
    logic             w_meas;
    logic             w_tmo;
    logic [CNT_W:0]   w_per_x;
    logic [CNT_W:0]   w_tgt_x;
    logic [CNT_W:0]   w_lo;
    logic [CNT_W:0]   w_hi;
    logic             w_fast;
    logic             w_slow;
    logic             w_inwin;
    logic [WIN_W-1:0] w_win_inc;
    logic [1:0]       w_state_nx;

    //------------------------------------------------------------------
    // fb_in synchronizer; edge is sync high with history still low
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= fb_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_edge   = r_sync2 & ~r_hist;
    assign w_active = (r_state == S_ARM) || (r_state == S_MEAS);
    assign w_sat    = (r_cnt_run == CNT_MAX);

    // An edge in the saturation cycle still counts as a measurement
    assign w_meas = (r_state == S_MEAS) && w_edge;
    assign w_tmo  = w_active && !w_edge && w_sat;

    //------------------------------------------------------------------
    // Window classification in CNT_W+1 bits; the lower bound clamps
    // at zero so a tiny target cannot wrap into "everything is fast"
    //------------------------------------------------------------------
    assign w_per_x = {1'b0, r_cnt_run};
    assign w_tgt_x = {1'b0, target_period};
    assign w_lo    = (w_tgt_x >= TOL_X) ? (w_tgt_x - TOL_X) : '0;
    assign w_hi    = w_tgt_x + TOL_X;
    assign w_fast  = (w_per_x < w_lo);
    assign w_slow  = (w_per_x > w_hi);
    assign w_inwin = !w_fast && !w_slow;

    assign w_win_inc = (r_win == WIN_FULL) ? r_win : (r_win + 1'b1);

    //------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        if (!en) begin
            w_state_nx = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: w_state_nx = S_ARM;
                S_ARM: begin
                    if (w_edge) begin
                        w_state_nx = S_MEAS;
                    end
                end
                S_MEAS: begin
                    if (w_tmo) begin
                        w_state_nx = S_ARM;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    //------------------------------------------------------------------
    // State, run counter, measurement and status registers
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt_run <= '0;
            r_win     <= '0;
            r_period  <= '0;
            r_vld     <= 1'b0;
            r_fast    <= 1'b0;
            r_slow    <= 1'b0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
        end else if (!en) begin
            // period is deliberately kept for software visibility
            r_state   <= S_IDLE;
            r_cnt_run <= '0;
            r_win     <= '0;
            r_vld     <= 1'b0;
            r_fast    <= 1'b0;
            r_slow    <= 1'b0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_vld   <= w_meas;

            if (!w_active) begin
                r_cnt_run <= '0;
            end else if (w_edge) begin
                r_cnt_run <= CNT_ONE;
            end else if (!w_sat) begin
                r_cnt_run <= r_cnt_run + 1'b1;
            end

            if (w_active && w_edge) begin
                r_timeout <= 1'b0;
            end else if (w_tmo) begin
                r_timeout <= 1'b1;
            end

            if (w_meas) begin
                r_period <= r_cnt_run;
                r_fast   <= w_fast;
                r_slow   <= w_slow;
                if (w_inwin) begin
                    r_win    <= w_win_inc;
                    r_locked <= (w_win_inc == WIN_FULL);
                end else begin
                    r_win    <= '0;
                    r_locked <= 1'b0;
                end
            end else if (w_tmo) begin
                // A lost feedback clock reads as infinitely slow
                r_fast   <= 1'b0;
                r_slow   <= 1'b1;
                r_locked <= 1'b0;
                r_win    <= '0;
            end
        end
    end

    assign period     = r_period;
    assign period_vld = r_vld;
    assign fast       = r_fast;
    assign slow       = r_slow;
    assign locked     = r_locked;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_freq_lock_det.sv
// Testbench for freq_lock_det: fb_in rising edges are placed on known
// clk cycles and an edge-timing model predicts every period_vld.
module tb_freq_lock_det;

    localparam int CNT_W  = 8;
    localparam int TOL    = 1;
    localparam int LOCK_N = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             en    = 1'b0;
    logic             fb_in = 1'b0;
    logic [CNT_W-1:0] target_period = 8'd16;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             fast;
    logic             slow;
    logic             locked;
    logic             timeout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // {period, fast, slow, locked}
    logic [10:0] obs_q[$];
    logic [10:0] exp_q[$];

    // Model: waiting for an arming edge, time of last edge, run of
    // in-window results, last reported period
    bit m_wait   = 1'b1;
    int m_last   = 0;
    int m_win    = 0;
    int m_period = 0;

    freq_lock_det #(
        .CNT_W (CNT_W),
        .TOL   (TOL),
        .LOCK_N(LOCK_N)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .fb_in        (fb_in),
        .target_period(target_period),
        .period       (period),
        .period_vld   (period_vld),
        .fast         (fast),
        .slow         (slow),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (period_vld === 1'b1) obs_q.push_back({period, fast, slow, locked});
    end

    // Reference: a measurement is the clk distance between two rising
    // edges; a gap above 2^CNT_W-1 means the block timed out and the
    // edge only re-arms it.
    task automatic model_rise();
        int gap;
        int lo;
        int hi;
        logic f;
        logic s;
        if (!en || !rst_n) return;
        if (m_wait) begin
            m_wait = 1'b0;
            m_last = cyc;
            return;
        end
        gap    = cyc - m_last;
        m_last = cyc;
        if (gap > 255) begin
            m_win = 0;
            return;
        end
        lo = (int'(target_period) >= TOL) ? int'(target_period) - TOL : 0;
        hi = int'(target_period) + TOL;
        f  = (gap < lo);
        s  = (gap > hi);
        if (f || s) m_win = 0;
        else if (m_win < LOCK_N) m_win++;
        m_period = gap;
        exp_q.push_back({8'(gap), f, s, (m_win == LOCK_N)});
    endtask

    // One rising edge now, next possible rising edge gap cycles later
    task automatic pulse(input int gap);
        @(negedge clk);
        fb_in = 1'b1;
        model_rise();
        repeat (gap / 2) @(negedge clk);
        fb_in = 1'b0;
        repeat (gap - gap / 2 - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({period, period_vld, fast, slow, locked, timeout} !== 13'd0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=0",
                     {period, period_vld, fast, slow, locked, timeout});
        end
        en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({period, period_vld, fast, slow, locked, timeout} !== 13'd0) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=0",
                     {period, period_vld, fast, slow, locked, timeout});
        end
        rst_n  = 1'b1;
        m_wait = 1'b1;
        m_win  = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_lock();
        repeat (6) pulse(16);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL lock vld_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL lock vld[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
        checks++;
        if ({locked, fast, slow, timeout, period} !== {4'b1000, 8'd16}) begin
            failures++;
            $display("FAIL lock_state got=%h exp=%h",
                     {locked, fast, slow, timeout, period}, {4'b1000, 8'd16});
        end
    endtask

    task automatic test_slow();
        repeat (4) pulse(20);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL slow vld_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL slow vld[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
        checks++;
        if ({period, fast, slow, locked} !== {8'd20, 3'b010}) begin
            failures++;
            $display("FAIL slow_state got=%h exp=%h",
                     {period, fast, slow, locked}, {8'd20, 3'b010});
        end
    endtask

    task automatic test_fast_boundary();
        repeat (3) pulse(12);
        repeat (4) @(negedge clk);
        checks++;
        if ({period, fast, slow, locked} !== {8'd12, 3'b100}) begin
            failures++;
            $display("FAIL fast_state got=%h exp=%h",
                     {period, fast, slow, locked}, {8'd12, 3'b100});
        end
        pulse(15);
        pulse(15);
        pulse(17);
        pulse(17);
        repeat (4) @(negedge clk);
        checks++;
        if ({period, fast, slow} !== {8'd17, 2'b00}) begin
            failures++;
            $display("FAIL boundary_state got=%h exp=%h",
                     {period, fast, slow}, {8'd17, 2'b00});
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL fastb vld_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL fastb vld[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_timeout();
        int t0;
        repeat (6) pulse(16);
        repeat (4) @(negedge clk);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL tmo_prelock got=%b exp=1", locked);
        end
        t0 = m_last;
        while (cyc < t0 + 250) @(negedge clk);
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL tmo_early got=%b exp=0", timeout);
        end
        while (cyc < t0 + 262) @(negedge clk);
        checks++;
        if ({timeout, slow, fast, locked, period_vld} !== 5'b11000) begin
            failures++;
            $display("FAIL tmo_set got=%b exp=11000",
                     {timeout, slow, fast, locked, period_vld});
        end
        pulse(16);
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL tmo_clear got=%b exp=0", timeout);
        end
        repeat (5) pulse(16);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL tmo vld_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL tmo vld[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_rst_mid_lock();
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL rst_prelock got=%b exp=1", locked);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({period, period_vld, fast, slow, locked, timeout} !== 13'd0) begin
            failures++;
            $display("FAIL rst_mid got=%h exp=0",
                     {period, period_vld, fast, slow, locked, timeout});
        end
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        m_wait = 1'b1;
        m_win  = 0;
        obs_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
        repeat (5) pulse(16);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL relock vld_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL relock vld[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_en_drop();
        logic [7:0] held;
        held = 8'(m_period);
        @(negedge clk);
        en     = 1'b0;
        m_wait = 1'b1;
        m_win  = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({locked, fast, slow, timeout, period_vld, period} !== {5'b0, held}) begin
            failures++;
            $display("FAIL en_off got=%h exp=%h",
                     {locked, fast, slow, timeout, period_vld, period}, {5'b0, held});
        end
        en = 1'b1;
        repeat (3) @(negedge clk);
        repeat (5) pulse(16);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL en vld_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL en vld[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        int t;
        int lo;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(9, 0) < 7) pulse($urandom_range(18, 14));
            else pulse($urandom_range(40, 4));
        end
        @(negedge clk);
        t = $urandom_range(30, 5);
        target_period = 8'(t);
        lo = (t - 3 < 4) ? 4 : t - 3;
        for (int i = 0; i < 30; i++) pulse($urandom_range(t + 3, lo));
        @(negedge clk);
        target_period = 8'd0;
        for (int i = 0; i < 6; i++) pulse($urandom_range(8, 4));
        @(negedge clk);
        target_period = 8'd16;
        for (int i = 0; i < 8; i++) pulse(16);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL rand vld_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rand vld[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_lock();
        test_slow();
        test_fast_boundary();
        test_timeout();
        test_rst_mid_lock();
        test_en_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
